// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 stream controller: block geometry and FSM state encoding.
package aes_pkg;
   localparam int AES_BLK_W  = 128;
   localparam int AES_WORD_W = 32;
   localparam int AES_WORDS  = 4;

   typedef enum logic [2:0] {
      IDLE,
      LD_KEY,
      LD_DATA,
      START,
      WAIT,
      OUT
   } aes_state_t;
endpackage

// File: rtl/aes_word_shreg.sv
// Output shift register: loads one 128-bit block and presents it most-significant word first
// over a valid/ready handshake, holding the current word while the consumer stalls.
module aes_word_shreg
   import aes_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_load,
   input  logic [AES_BLK_W-1:0]  i_block,
   input  logic                  i_ready,
   output logic                  o_valid,
   output logic [AES_WORD_W-1:0] o_data,
   output logic                  o_last
);
   logic [AES_BLK_W-1:0] r_buf;
   logic [1:0]           r_cnt;
   logic                 r_valid;
   logic                 w_fire;

   assign w_fire  = r_valid & i_ready;
   assign o_last  = w_fire & (r_cnt == 2'(AES_WORDS - 1));
   assign o_valid = r_valid;
   assign o_data  = r_buf[AES_BLK_W-1 -: AES_WORD_W];

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_buf   <= '0;
         r_cnt   <= 2'd0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_buf   <= i_block;
         r_cnt   <= 2'd0;
         r_valid <= 1'b1;
      end else if (w_fire) begin
         // zero-fill keeps out_data at 0 once the block has drained
         r_buf <= {r_buf[AES_BLK_W-AES_WORD_W-1:0], {AES_WORD_W{1'b0}}};
         r_cnt <= r_cnt + 2'd1;
         if (o_last) begin
            r_valid <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/aes_stream_ctrl.sv
// Word-serial load/unload controller around the iterative AES-128 core.
// Optional build macro AES_KEY_HOLD_EN adds the key_hold input to reuse the last loaded key.
module aes_stream_ctrl
   import aes_pkg::*;
#(
   parameter int CORE_LAT = 12,
   parameter int CNT_W    = 4
)(
   input  logic                  clk,
   input  logic                  reset,
`ifdef AES_KEY_HOLD_EN
   input  logic                  key_hold,
`endif
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [AES_WORD_W-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [AES_WORD_W-1:0] out_data,
   output logic                  busy,
   output logic [AES_BLK_W-1:0]  core_data,
   output logic [AES_BLK_W-1:0]  core_key,
   output logic                  core_rst_n,
   input  logic [AES_BLK_W-1:0]  core_result
);
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(CORE_LAT - 1);

   aes_state_t       r_state;
   aes_state_t       w_state_next;
   logic [1:0]       r_word_idx;
   logic [CNT_W-1:0] r_lat_cnt;
   logic             r_core_rst_n;
   logic             w_accept;
   logic             w_last_word;
   logic             w_skip_key;
   logic             w_load_out;
   logic             w_out_last;

   assign in_ready    = (r_state == LD_KEY) || (r_state == LD_DATA);
   assign w_accept    = in_valid & in_ready;
   assign w_last_word = w_accept & (r_word_idx == 2'(AES_WORDS - 1));
   assign busy        = (r_state != IDLE);
   assign core_rst_n  = r_core_rst_n;

`ifdef AES_KEY_HOLD_EN
   logic r_key_loaded;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_key_loaded <= 1'b0;
      end else if ((r_state == LD_KEY) && w_last_word) begin
         r_key_loaded <= 1'b1;
      end
   end

   assign w_skip_key = key_hold & r_key_loaded;
`else
   assign w_skip_key = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      w_load_out   = 1'b0;
      case (r_state)
         IDLE:    w_state_next = w_skip_key ? LD_DATA : LD_KEY;
         LD_KEY:  if (w_last_word) w_state_next = LD_DATA;
         LD_DATA: if (w_last_word) w_state_next = START;
         START:   w_state_next = WAIT;
         WAIT: begin
            if (r_lat_cnt == LAT_LAST) begin
               w_load_out   = 1'b1;
               w_state_next = OUT;
            end
         end
         OUT:     if (w_out_last) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_word_idx   <= 2'd0;
         r_lat_cnt    <= '0;
         r_core_rst_n <= 1'b0;
      end else begin
         r_state <= w_state_next;
         // core is held in reset exactly for the single START cycle
         r_core_rst_n <= (w_state_next != START);
         if (w_accept) begin
            r_word_idx <= r_word_idx + 2'd1;
         end
         if (r_state == START) begin
            r_lat_cnt <= '0;
         end else if (r_state == WAIT) begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
         end
      end
   end

   // Word k of each phase lands in bits [127-32k -: 32] of the key or plaintext.
   genvar gi;
   generate
      for (gi = 0; gi < AES_WORDS; gi++) begin : g_pack
         logic [AES_WORD_W-1:0] r_key_word;
         logic [AES_WORD_W-1:0] r_data_word;
         logic                  w_hit;

         assign w_hit = w_accept && (r_word_idx == 2'(gi));

         always_ff @(posedge clk) begin
            if (!reset) begin
               r_key_word  <= '0;
               r_data_word <= '0;
            end else if (w_hit && (r_state == LD_KEY)) begin
               r_key_word <= in_data;
            end else if (w_hit && (r_state == LD_DATA)) begin
               r_data_word <= in_data;
            end
         end

         assign core_key[AES_BLK_W-1-AES_WORD_W*gi -: AES_WORD_W]  = r_key_word;
         assign core_data[AES_BLK_W-1-AES_WORD_W*gi -: AES_WORD_W] = r_data_word;
      end
   endgenerate

   aes_word_shreg u_out_shreg (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load_out),
      .i_block (core_result),
      .i_ready (out_ready),
      .o_valid (out_valid),
      .o_data  (out_data),
      .o_last  (w_out_last)
   );
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl: behavioural AES-128 core model plus randomized stream stimulus.
// Build with AES_KEY_HOLD_EN defined to also exercise the key_hold path.
module tb_aes_stream_ctrl;
   localparam int CORE_LAT = 12;
   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] HOLD_CT  = 128'h0a940bb5416ef045f1c39458c653ea5a;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         key_hold = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [31:0]  in_data = 32'h0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [31:0]  out_data;
   logic         busy;
   logic [127:0] core_data;
   logic [127:0] core_key;
   logic         core_rst_n;
   logic [127:0] core_result;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_stream_ctrl #(.CORE_LAT(CORE_LAT), .CNT_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
`ifdef AES_KEY_HOLD_EN
      .key_hold    (key_hold),
`endif
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy),
      .core_data   (core_data),
      .core_key    (core_key),
      .core_rst_n  (core_rst_n),
      .core_result (core_result)
   );

   // ---------------- AES-128 reference ----------------
   logic [7:0] sbox_tab [256];

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xt(aa);
      end
      return p;
   endfunction

   initial begin
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                     ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   end

   function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rcon;
      logic [31:0]  tmp;
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]}
                  ^ {rcon, 24'h0};
            rcon = xt(rcon);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (r != 10) begin
               s[4*c]   = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
               s[4*c+3] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
            end else begin
               s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // Core model: result is garbage until 11 rounds have elapsed since core_rst_n release.
   int           rounds = 0;
   logic [127:0] core_aes = '0;
   always @(posedge clk) begin
      if (!core_rst_n) rounds <= 0;
      else if (rounds < 20) rounds <= rounds + 1;
      core_aes <= aes_enc(core_key, core_data);
   end
   assign core_result = (rounds >= 11) ? core_aes : {4{32'hbad00000 ^ 32'(rounds)}};

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ctl"}, {in_ready, out_valid, out_data, busy, core_rst_n}, '0);
      chk({tag, "_key"}, core_key, '0);
      chk({tag, "_data"}, core_data, '0);
   endtask

   // Feeds key (optional) and plaintext words; stall 0=always valid, 1=toggle, 2=random.
   task automatic load(input string tag, input logic [127:0] key, input logic [127:0] pt,
                       input bit with_key, input int stall, output int hs);
      logic [31:0] w [8];
      int n, sent, guard;
      n = with_key ? 8 : 4;
      sent = 0;
      guard = 0;
      for (int i = 0; i < 4; i++) begin
         w[i]   = with_key ? key[127-32*i -: 32] : pt[127-32*i -: 32];
         w[i+4] = pt[127-32*i -: 32];
      end
      hs = cyc;
      while (sent < n && guard < 200) begin
         @(negedge clk);
         guard++;
         case (stall)
            0:       in_valid = 1'b1;
            1:       in_valid = (guard % 2 == 1);
            default: in_valid = 1'($urandom_range(0, 1));
         endcase
         in_data = in_valid ? w[sent] : $urandom;
         if (in_valid && in_ready) begin
            sent++;
            if (sent == n) hs = cyc + 1;
         end
      end
      chk({tag, "_in_words"}, sent, n);
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_core_key"}, core_key, key);
      chk({tag, "_core_data"}, core_data, pt);
      chk({tag, "_core_rst_start"}, {busy, core_rst_n}, 2'b10);
   endtask

   // Collects 4 output words; bp>0 = ready low that many OUT cycles, bp<0 = random ready.
   task automatic drain(input string tag, input logic [127:0] exp, input int hs, input int bp);
      int got_n, guard, stall_left;
      bit seen;
      logic [127:0] got;
      got_n = 0; guard = 0; stall_left = bp; seen = 0; got = '0;
      while (got_n < 4 && guard < 300) begin
         @(negedge clk);
         guard++;
         if (out_valid) begin
            in_valid = 1'b0;
            if (!seen) begin
               seen = 1;
               chk({tag, "_latency"}, cyc + 1 - hs, CORE_LAT + 2);
            end
            if (stall_left > 0) begin
               out_ready = 1'b0;
               stall_left--;
               chk({tag, "_hold"}, {out_valid, out_data}, {1'b1, exp[127:96]});
            end else begin
               out_ready = (bp < 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (out_ready) begin
               got = {got[95:0], out_data};
               got_n++;
            end
         end else begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
         end
      end
      chk({tag, "_out_words"}, got_n, 4);
      chk({tag, "_cipher"}, got, exp);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_done_idle"}, {out_valid, busy}, 2'b00);
   endtask

   initial begin
      int hs;
      int seen_ov;
      logic [127:0] k, p;

      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      reset = 1'b1;

      load("fips_bp", FIPS_KEY, FIPS_PT, 1'b1, 0, hs);
      drain("fips_bp", FIPS_CT, hs, 5);

`ifdef AES_KEY_HOLD_EN
      key_hold = 1'b1;
      load("hold", FIPS_KEY, 128'h0, 1'b0, 0, hs);
      key_hold = 1'b0;
      drain("hold", HOLD_CT, hs, 0);
`endif

      load("fips_toggle", FIPS_KEY, FIPS_PT, 1'b1, 1, hs);
      drain("fips_toggle", FIPS_CT, hs, 0);

      for (int b = 0; b < 4; b++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         p = {$urandom, $urandom, $urandom, $urandom};
         load($sformatf("rand%0d", b), k, p, 1'b1, 2, hs);
         drain($sformatf("rand%0d", b), aes_enc(k, p), hs, (b == 1) ? 3 : -1);
      end

      // abort during WAIT when the latency counter reads 5
      load("abort", FIPS_KEY, FIPS_PT, 1'b1, 2, hs);
      while (cyc < hs + 6) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_reset_vals("abort_reset");
      reset = 1'b1;
      seen_ov = 0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid) seen_ov++;
      end
      chk("abort_no_out", seen_ov, 0);

      load("after_abort", FIPS_KEY, FIPS_PT, 1'b1, 2, hs);
      drain("after_abort", FIPS_CT, hs, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
